// File: rtl/freq_generator.sv
// freq_generator: square-wave generator whose half-period comes from an iterative restoring divide of CLK_HZ by 2*freq_in.
module freq_generator #(
  parameter int CLK_HZ = 100000000,
  parameter int WIDTH  = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] freq_in,
  input  logic             load,
  input  logic             enable,
  output logic             OUT,
  output logic             ready,
  output logic             busy,
  output logic             error,
  output logic [WIDTH-1:0] half_period,
  output logic [WIDTH-1:0] edge_count
);
  localparam logic [WIDTH-1:0] DVD  = WIDTH'(CLK_HZ);
  localparam logic [WIDTH-1:0] MAXF = WIDTH'(CLK_HZ / 2);
  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;
  state_t           state_q, state_d;
  logic             out_q, out_d, err_q, err_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, quo_q, quo_d, hp_q, hp_d, ec_q, ec_d;
  logic [WIDTH:0]   rem_q, rem_d, div_q, div_d;
  logic [WIDTH+1:0] trial, diff;
  logic             ge;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      hp_q    <= '0;
      ec_q    <= '0;
      rem_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      hp_q    <= hp_d;
      ec_q    <= ec_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end
  // quo_q starts as the dividend and shifts quotient bits in from the right as dividend bits leave on the left
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, div_q};
  assign ge    = trial >= {1'b0, div_q};
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    hp_d    = hp_q;
    ec_d    = ec_q;
    rem_d   = rem_q;
    div_d   = div_q;
    if (load && state_q != DIVIDE) begin
      out_d   = 1'b0;
      cnt_d   = '0;
      err_d   = (freq_in == '0) || (freq_in > MAXF);
      state_d = err_d ? IDLE : DIVIDE;
      div_d   = err_d ? div_q : {freq_in, 1'b0};
      rem_d   = err_d ? rem_q : '0;
      quo_d   = err_d ? quo_q : DVD;
      ec_d    = err_d ? ec_q : '0;
    end else if (state_q == DIVIDE) begin
      rem_d = ge ? diff[WIDTH:0] : trial[WIDTH:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == WIDTH'(WIDTH - 1)) begin
        hp_d    = quo_d;
        state_d = RUN;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    end else if (state_q == RUN) begin
      if (!enable) begin
        out_d = 1'b0;
        cnt_d = '0;
      end else if (cnt_q == hp_q - 1'b1) begin
        out_d = !out_q;
        cnt_d = '0;
        ec_d  = out_q ? ec_q : ec_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  assign OUT         = out_q;
  assign ready       = state_q == RUN;
  assign busy        = state_q == DIVIDE;
  assign error       = err_q;
  assign half_period = hp_q;
  assign edge_count  = ec_q;
endmodule

// File: tb/tb_freq_generator.sv
// tb_freq_generator: directed stimulus with a scoreboard of expected half-periods checked when ready rises.
module tb_freq_generator;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] freq_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        OUT, ready, busy, error;
  logic [31:0] half_period, edge_count;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  v;

  freq_generator #(.CLK_HZ(100000000), .WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .freq_in(freq_in), .load(load), .enable(enable),
    .OUT(OUT), .ready(ready), .busy(busy), .error(error),
    .half_period(half_period), .edge_count(edge_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [31:0] f);
    freq_in = f;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // monitor: counts busy cycles and, on each ready rise, pops the expected half-period
  initial begin
    int   busy_cnt;
    logic rdy_prev;
    logic [31:0] e;
    busy_cnt = 0;
    rdy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (busy) busy_cnt++;
      else begin
        if (ready && !rdy_prev) begin
          if (exp_q.size() == 0) chk("sb_unexpected_ready", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("sb_busy_cycles", busy_cnt, 32'd32);
            chk("sb_half_period", half_period, e);
          end
        end
        busy_cnt = 0;
      end
      rdy_prev = ready;
    end
  end

  initial begin
    tick(2);
    chk("rst_out", OUT, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_hp", half_period, 0);
    chk("rst_ec", edge_count, 0);
    RESET = 1'b1;
    tick(1);
    enable = 1'b1;
    exp_q.push_back(32'd2);
    do_load(32'd25000000);
    chk("25m_busy", busy, 1);
    chk("25m_ready0", ready, 0);
    tick(32);
    chk("25m_ready", ready, 1);
    chk("25m_hp", half_period, 2);
    chk("25m_out0", OUT, 0);
    chk("25m_ec0", edge_count, 0);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      v = {v[6:0], OUT};
    end
    chk("25m_wave", v, 8'h66);
    tick(32);
    chk("25m_ec10", edge_count, 10);
    exp_q.push_back(32'd1);
    do_load(32'd50000000);
    tick(32);
    chk("50m_ready", ready, 1);
    chk("50m_error", error, 0);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      v = {v[6:0], OUT};
    end
    chk("50m_wave", v, 8'h0a);
    exp_q.push_back(32'd16);
    do_load(32'd3000000);
    tick(32);
    chk("3m_hp", half_period, 16);
    tick(15);
    chk("3m_low", OUT, 0);
    tick(1);
    chk("3m_rise", OUT, 1);
    tick(15);
    chk("3m_high", OUT, 1);
    tick(1);
    chk("3m_fall", OUT, 0);
    do_load(32'd0);
    chk("f0_error", error, 1);
    chk("f0_ready", ready, 0);
    chk("f0_out", OUT, 0);
    chk("f0_busy", busy, 0);
    do_load(32'd50000001);
    chk("fhi_error", error, 1);
    chk("fhi_busy", busy, 0);
    exp_q.push_back(32'd50);
    do_load(32'd1000000);
    chk("1m_error_clr", error, 0);
    chk("1m_busy", busy, 1);
    tick(32);
    tick(60);
    chk("1m_out_high", OUT, 1);
    chk("1m_ec", edge_count, 1);
    exp_q.push_back(32'd5);
    do_load(32'd10000000);
    chk("reload_out", OUT, 0);
    chk("reload_ready", ready, 0);
    chk("reload_busy", busy, 1);
    chk("reload_ec", edge_count, 0);
    chk("reload_hp_hold", half_period, 50);
    tick(5);
    do_load(32'd25000000);
    tick(26);
    chk("10m_ready", ready, 1);
    chk("10m_hp", half_period, 5);
    tick(5);
    chk("en_high", OUT, 1);
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("en_off_out", OUT, 0);
    tick(3);
    chk("en_off_hold", OUT, 0);
    enable = 1'b1;
    tick(4);
    chk("en_on_low", OUT, 0);
    tick(1);
    chk("en_on_rise", OUT, 1);
    chk("en_ec", edge_count, 2);
    do_load(32'd25000000);
    tick(9);
    chk("mid_busy", busy, 1);
    RESET = 1'b0;
    #2;
    chk("arst_out", OUT, 0);
    chk("arst_ready", ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hp", half_period, 0);
    chk("arst_ec", edge_count, 0);
    tick(2);
    RESET = 1'b1;
    tick(40);
    chk("post_rst_ready", ready, 0);
    chk("post_rst_busy", busy, 0);
    exp_q.push_back(32'd1);
    do_load(32'd50000000);
    tick(32);
    chk("recover_ready", ready, 1);
    tick(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
